alu_muldiv: RTL

- Parametrised, multi-cycle successor to the single-cycle ALU. Executes the RV32M multiply/divide group, generalised to WIDTH bits.
- Sits beside the combinational ALU in the execute stage. The core stalls on in_ready / out_valid.
- Iterative engine: shift-add multiplier and restoring divider, one result bit per cycle, with a valid/ready handshake on both sides.

---
 rtl/alu_muldiv.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/alu_muldiv.sv
//==============================================================================
// Module   : alu_muldiv
// Purpose  : Iterative RV32M multiply/divide unit (shift-add / restoring).
// Revision : 1.0
//==============================================================================
`default_nettype none

module alu_muldiv #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] opA,
   input  logic [WIDTH-1:0] opB,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             busy
);

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_REM    = 3'b110;

   localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_CALC = 2'b01,
      S_DONE = 2'b10
   } state_t;

   state_t             state_q;
   logic [2:0]         op_q;
   logic [WIDTH-1:0]   acc_q;
   logic [WIDTH-1:0]   lo_q;
   logic [WIDTH-1:0]   opnd_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               negq_q;
   logic               negr_q;
   logic [WIDTH-1:0]   result_q;
   logic               in_ready_q;
   logic               out_valid_q;
   logic               busy_q;

   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic               fast;
   logic [WIDTH-1:0]   fast_res;

   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH:0]     rem_diff;
   logic               rem_ge;
   logic [WIDTH-1:0]   acc_d;
   logic [WIDTH-1:0]   lo_d;
   logic [2*WIDTH-1:0] prod_s;
   logic [WIDTH-1:0]   quo_s;
   logic [WIDTH-1:0]   rem_s;
   logic [WIDTH-1:0]   res_d;

   // Request decode: operand magnitudes, sign flags and the no-iteration cases.
   always_comb begin
      a_neg    = 1'b0;
      b_neg    = 1'b0;
      fast     = 1'b0;
      fast_res = '0;
      if (op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM)
         a_neg = opA[WIDTH-1];
      if (op == OP_MULH || op == OP_DIV || op == OP_REM)
         b_neg = opB[WIDTH-1];
      a_mag = a_neg ? -opA : opA;
      b_mag = b_neg ? -opB : opB;
      if (op[2] && opB == '0) begin
         fast     = 1'b1;
         fast_res = op[1] ? opA : '1;
      end else if (op[2] && !op[0] && opA == MIN_NEG && opB == '1) begin
         fast     = 1'b1;
         fast_res = op[1] ? '0 : opA;
      end
   end

   // One iteration: acc holds product-high / partial remainder, lo holds
   // multiplier-then-product-low / dividend-then-quotient.
   always_comb begin
      mul_sum  = {1'b0, acc_q} + {1'b0, (lo_q[0] ? opnd_q : '0)};
      rem_sh   = {acc_q, lo_q[WIDTH-1]};
      rem_diff = rem_sh - {1'b0, opnd_q};
      rem_ge   = ~rem_diff[WIDTH];
      if (op_q[2]) begin
         acc_d = rem_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
         lo_d  = {lo_q[WIDTH-2:0], rem_ge};
      end else begin
         acc_d = mul_sum[WIDTH:1];
         lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
      end
      prod_s = negq_q ? -{acc_d, lo_d} : {acc_d, lo_d};
      quo_s  = negq_q ? -lo_d : lo_d;
      rem_s  = negr_q ? -acc_d : acc_d;
      if (op_q[2])
         res_d = op_q[1] ? rem_s : quo_s;
      else if (op_q == OP_MUL)
         res_d = prod_s[WIDTH-1:0];
      else
         res_d = prod_s[2*WIDTH-1:WIDTH];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         op_q        <= '0;
         acc_q       <= '0;
         lo_q        <= '0;
         opnd_q      <= '0;
         cnt_q       <= '0;
         negq_q      <= 1'b0;
         negr_q      <= 1'b0;
         result_q    <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid && in_ready_q) begin
                  op_q       <= op;
                  acc_q      <= '0;
                  cnt_q      <= '0;
                  negq_q     <= a_neg ^ b_neg;
                  negr_q     <= a_neg;
                  lo_q       <= op[2] ? a_mag : b_mag;
                  opnd_q     <= op[2] ? b_mag : a_mag;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  if (fast) begin
                     result_q    <= fast_res;
                     out_valid_q <= 1'b1;
                     state_q     <= S_DONE;
                  end else begin
                     state_q     <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               acc_q <= acc_d;
               lo_q  <= lo_d;
               if (cnt_q == LAST) begin
                  result_q    <= res_d;
                  out_valid_q <= 1'b1;
                  state_q     <= S_DONE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign busy      = busy_q;

endmodule

`default_nettype wire
